// File: rtl/sii_ncu_link_arb.sv
// Inbound SII->NCU link scheduler: round-robin between rdq and intq, request/grant handshake,
// then streams the held packet as 32-bit beats with per-halfword even parity.
module sii_ncu_link_arb #(
  parameter int unsigned BEATS       = 4,
  parameter int unsigned GNT_TIMEOUT = 1024
) (
  input  logic                iol2clk,
  input  logic                rst,
  input  logic                rdq_vld,
  input  logic [32*BEATS-1:0] rdq_pkt,
  output logic                rdq_ack,
  input  logic                intq_vld,
  input  logic [32*BEATS-1:0] intq_pkt,
  output logic                intq_ack,
  output logic                sii_ncu_req,
  input  logic                ncu_sii_gnt,
  output logic [31:0]         sii_ncu_data,
  output logic [1:0]          sii_ncu_dparity,
  input  logic                par_inj,
  output logic                gnt_timeout,
  output logic                gnt_unexp
);

  localparam int unsigned PKT_W  = 32 * BEATS;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned TMO_W  = 16;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(GNT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              win_id_q, win_id_d;
  logic [PKT_W-1:0]  held_q, held_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              req_q, req_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        par_q, par_d;
  logic              rdq_ack_q, rdq_ack_d;
  logic              intq_ack_q, intq_ack_d;
  logic              tmo_q, tmo_d;
  logic              unexp_q, unexp_d;

  logic              drive;
  logic [BEAT_W-1:0] drive_idx;
  logic              pick;

  // Beat 0 is the most significant word of the packet.
  function automatic logic [31:0] beat_of(input logic [PKT_W-1:0] pkt,
                                          input logic [BEAT_W-1:0] idx);
    logic [PKT_W-1:0] sh;
    sh = pkt >> (32 * (BEATS - 1 - 32'(idx)));
    return sh[31:0];
  endfunction

  function automatic logic [1:0] par_of(input logic [31:0] b, input logic inj);
    return {^b[31:16], (^b[15:0]) ^ inj};
  endfunction

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 1'b0;
      win_id_q   <= 1'b0;
      held_q     <= '0;
      beat_q     <= '0;
      tmo_cnt_q  <= '0;
      req_q      <= 1'b0;
      data_q     <= '0;
      par_q      <= '0;
      rdq_ack_q  <= 1'b0;
      intq_ack_q <= 1'b0;
      tmo_q      <= 1'b0;
      unexp_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      win_id_q   <= win_id_d;
      held_q     <= held_d;
      beat_q     <= beat_d;
      tmo_cnt_q  <= tmo_cnt_d;
      req_q      <= req_d;
      data_q     <= data_d;
      par_q      <= par_d;
      rdq_ack_q  <= rdq_ack_d;
      intq_ack_q <= intq_ack_d;
      tmo_q      <= tmo_d;
      unexp_q    <= unexp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    win_id_d   = win_id_q;
    held_d     = held_q;
    beat_d     = beat_q;
    tmo_cnt_d  = tmo_cnt_q;
    req_d      = 1'b0;
    data_d     = '0;
    par_d      = '0;
    rdq_ack_d  = 1'b0;
    intq_ack_d = 1'b0;
    tmo_d      = 1'b0;
    unexp_d    = ncu_sii_gnt && (state_q != ST_REQ);
    drive      = 1'b0;
    drive_idx  = '0;
    pick       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmo_cnt_d = '0;
        if (rdq_vld || intq_vld) begin
          pick     = (rdq_vld && intq_vld) ? rr_ptr_q : intq_vld;
          win_id_d = pick;
          held_d   = pick ? intq_pkt : rdq_pkt;
          req_d    = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ncu_sii_gnt) begin
          state_d   = ST_XFER;
          tmo_cnt_d = '0;
          drive     = 1'b1;
          drive_idx = '0;
        end else begin
          req_d = 1'b1;
          // Timeout only reports; the request stays up until granted.
          if (tmo_cnt_q == TMO_LAST) begin
            tmo_d     = 1'b1;
            tmo_cnt_d = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end
      end
      ST_XFER: begin
        if (beat_q == LAST_BEAT) begin
          state_d = ST_IDLE;
        end else begin
          drive     = 1'b1;
          drive_idx = beat_q + BEAT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load the next beat; the ack rides along with the last one.
    if (drive) begin
      beat_d = drive_idx;
      data_d = beat_of(held_q, drive_idx);
      par_d  = par_of(data_d, par_inj);
      if (drive_idx == LAST_BEAT) begin
        rdq_ack_d  = ~win_id_q;
        intq_ack_d = win_id_q;
        rr_ptr_d   = ~win_id_q;
      end
    end
  end

  assign sii_ncu_req     = req_q;
  assign sii_ncu_data    = data_q;
  assign sii_ncu_dparity = par_q;
  assign rdq_ack         = rdq_ack_q;
  assign intq_ack        = intq_ack_q;
  assign gnt_timeout     = tmo_q;
  assign gnt_unexp       = unexp_q;

endmodule

// File: tb/tb_sii_ncu_link_arb.sv
// Self-checking bench for sii_ncu_link_arb: directed scenarios plus randomized traffic
// compared against a packet-level reference model.
`timescale 1ns/1ps
module tb_sii_ncu_link_arb;

  localparam int unsigned BEATS       = 4;
  localparam int unsigned GNT_TIMEOUT = 8;
  localparam int unsigned PKT_W       = 32 * BEATS;

  logic             iol2clk = 1'b0;
  logic             rst = 1'b1;
  logic             rdq_vld = 1'b0;
  logic [PKT_W-1:0] rdq_pkt = '0;
  logic             rdq_ack;
  logic             intq_vld = 1'b0;
  logic [PKT_W-1:0] intq_pkt = '0;
  logic             intq_ack;
  logic             sii_ncu_req;
  logic             ncu_sii_gnt = 1'b0;
  logic [31:0]      sii_ncu_data;
  logic [1:0]       sii_ncu_dparity;
  logic             par_inj = 1'b0;
  logic             gnt_timeout;
  logic             gnt_unexp;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_rr   = 1'b0;

  logic [31:0] cap_data [BEATS];
  logic [1:0]  cap_par  [BEATS];
  logic [1:0]  cap_ack  [BEATS];
  logic        cap_req  [BEATS];

  sii_ncu_link_arb #(.BEATS(BEATS), .GNT_TIMEOUT(GNT_TIMEOUT)) dut (
    .iol2clk        (iol2clk),
    .rst            (rst),
    .rdq_vld        (rdq_vld),
    .rdq_pkt        (rdq_pkt),
    .rdq_ack        (rdq_ack),
    .intq_vld       (intq_vld),
    .intq_pkt       (intq_pkt),
    .intq_ack       (intq_ack),
    .sii_ncu_req    (sii_ncu_req),
    .ncu_sii_gnt    (ncu_sii_gnt),
    .sii_ncu_data   (sii_ncu_data),
    .sii_ncu_dparity(sii_ncu_dparity),
    .par_inj        (par_inj),
    .gnt_timeout    (gnt_timeout),
    .gnt_unexp      (gnt_unexp)
  );

  always #5 iol2clk = ~iol2clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [PKT_W-1:0] rand_pkt();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [31:0] exp_beat(input logic [PKT_W-1:0] pkt, input int n);
    return pkt[32*(int'(BEATS)-n)-1 -: 32];
  endfunction

  function automatic logic [1:0] exp_par(input logic [31:0] d, input logic inj);
    logic hi, lo;
    hi = ($countones(d[31:16]) % 2) != 0;
    lo = (($countones(d[15:0]) % 2) != 0) ^ inj;
    return {hi, lo};
  endfunction

  function automatic logic [1:0] exp_ack(input int n, input bit w);
    if (n != int'(BEATS) - 1) return 2'b00;
    return w ? 2'b10 : 2'b01;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge iol2clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst         = 1'b1;
    ncu_sii_gnt = 1'b0;
    par_inj     = 1'b0;
    repeat (cycles) step();
    rst    = 1'b0;
    exp_rr = 1'b0;
  endtask

  task automatic wait_req(input int budget, output bit seen);
    seen = sii_ncu_req;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = sii_ncu_req;
    end
  endtask

  // Grants after dly REQ cycles and records every beat; returns on the last-beat cycle.
  task automatic grant_capture(input int dly);
    repeat (dly) step();
    ncu_sii_gnt = 1'b1;
    step();
    ncu_sii_gnt = 1'b0;
    for (int n = 0; n < int'(BEATS); n++) begin
      cap_data[n] = sii_ncu_data;
      cap_par[n]  = sii_ncu_dparity;
      cap_ack[n]  = {intq_ack, rdq_ack};
      cap_req[n]  = sii_ncu_req;
      if (n < int'(BEATS) - 1) step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [38:0]      obs;
    logic [PKT_W-1:0] p;
    p        = rand_pkt();
    rdq_pkt  = p;
    rdq_vld  = 1'b1;
    intq_vld = 1'b0;
    rst      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {sii_ncu_req, sii_ncu_data, sii_ncu_dparity, rdq_ack, intq_ack, gnt_timeout, gnt_unexp};
      n_checks++;
      if (obs !== 39'd0) $display("FAIL reset_outputs cycle %0d: got %h want 0", i, obs);
      else n_pass++;
    end
    rst    = 1'b0;
    exp_rr = 1'b0;
    step();
    n_checks++;
    if (sii_ncu_req !== 1'b1) $display("FAIL reset_release_req: got %b want 1", sii_ncu_req);
    else n_pass++;
    grant_capture(int'($urandom_range(0, 3)));
    for (int n = 0; n < int'(BEATS); n++) begin
      n_checks++;
      if (cap_data[n] !== exp_beat(p, n) || cap_ack[n] !== exp_ack(n, 1'b0))
        $display("FAIL reset_first_pkt beat %0d: got %h/%b want %h/%b",
                 n, cap_data[n], cap_ack[n], exp_beat(p, n), exp_ack(n, 1'b0));
      else n_pass++;
    end
    rdq_vld = 1'b0;
    exp_rr  = 1'b1;
    step();
  endtask

  task automatic test_single_packet();
    logic [PKT_W-1:0] p;
    logic [31:0]      want [BEATS];
    bit               seen;
    do_reset(2);
    p       = 128'h11112222_33334444_55550000_0000FFFF;
    want[0] = 32'h11112222;
    want[1] = 32'h33334444;
    want[2] = 32'h55550000;
    want[3] = 32'h0000FFFF;
    rdq_pkt  = p;
    rdq_vld  = 1'b1;
    intq_vld = 1'b0;
    wait_req(4, seen);
    n_checks++;
    if (seen !== 1'b1) $display("FAIL single_req: got %b want 1", seen);
    else n_pass++;
    grant_capture(5);
    for (int n = 0; n < int'(BEATS); n++) begin
      n_checks++;
      if (cap_data[n] !== want[n] || cap_par[n] !== 2'b00 || cap_ack[n] !== exp_ack(n, 1'b0) ||
          cap_req[n] !== 1'b0)
        $display("FAIL single_beat %0d: got d=%h p=%b a=%b r=%b want d=%h p=00 a=%b r=0",
                 n, cap_data[n], cap_par[n], cap_ack[n], cap_req[n], want[n], exp_ack(n, 1'b0));
      else n_pass++;
    end
    rdq_vld = 1'b0;
    step();
    n_checks++;
    if ({sii_ncu_req, sii_ncu_data, rdq_ack} !== 34'd0)
      $display("FAIL single_idle: got req=%b data=%h ack=%b want 0", sii_ncu_req, sii_ncu_data, rdq_ack);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [PKT_W-1:0] pr, pi, p;
    bit               seen, w;
    do_reset(2);
    pr = rand_pkt();
    pi = rand_pkt();
    rdq_pkt  = pr;
    intq_pkt = pi;
    rdq_vld  = 1'b1;
    intq_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_req(6, seen);
      n_checks++;
      if (seen !== 1'b1) $display("FAIL b2b_req pkt %0d: got %b want 1", k, seen);
      else n_pass++;
      w = exp_rr;
      p = w ? pi : pr;
      grant_capture(0);
      for (int n = 0; n < int'(BEATS); n++) begin
        n_checks++;
        if (cap_data[n] !== exp_beat(p, n) || cap_ack[n] !== exp_ack(n, w))
          $display("FAIL b2b_beat pkt %0d beat %0d: got %h/%b want %h/%b",
                   k, n, cap_data[n], cap_ack[n], exp_beat(p, n), exp_ack(n, w));
        else n_pass++;
      end
      exp_rr = ~w;
      if (w) begin
        pi = rand_pkt();
        intq_pkt = pi;
      end else begin
        pr = rand_pkt();
        rdq_pkt = pr;
      end
      step();
      n_checks++;
      if ({sii_ncu_req, sii_ncu_data} !== 33'd0)
        $display("FAIL b2b_gap pkt %0d: got req=%b data=%h want 0", k, sii_ncu_req, sii_ncu_data);
      else n_pass++;
      step();
      n_checks++;
      if (sii_ncu_req !== 1'b1) $display("FAIL b2b_rereq pkt %0d: got %b want 1", k, sii_ncu_req);
      else n_pass++;
    end
    rdq_vld  = 1'b0;
    intq_vld = 1'b0;
  endtask

  task automatic test_timeout();
    logic [PKT_W-1:0] p;
    bit               seen, want_t;
    do_reset(2);
    p        = rand_pkt();
    intq_pkt = p;
    intq_vld = 1'b1;
    rdq_vld  = 1'b0;
    wait_req(4, seen);
    n_checks++;
    if (seen !== 1'b1) $display("FAIL tmo_req: got %b want 1", seen);
    else n_pass++;
    for (int k = 1; k <= 20; k++) begin
      step();
      want_t = (k % int'(GNT_TIMEOUT)) == 0;
      n_checks++;
      if (gnt_timeout !== want_t || sii_ncu_req !== 1'b1)
        $display("FAIL tmo_cycle %0d: got tmo=%b req=%b want tmo=%b req=1", k, gnt_timeout, sii_ncu_req, want_t);
      else n_pass++;
    end
    grant_capture(0);
    for (int n = 0; n < int'(BEATS); n++) begin
      n_checks++;
      if (cap_data[n] !== exp_beat(p, n) || cap_ack[n] !== exp_ack(n, 1'b1))
        $display("FAIL tmo_beat %0d: got %h/%b want %h/%b",
                 n, cap_data[n], cap_ack[n], exp_beat(p, n), exp_ack(n, 1'b1));
      else n_pass++;
    end
    intq_vld = 1'b0;
    step();
  endtask

  task automatic test_unexp_parity();
    logic [PKT_W-1:0] p;
    bit               seen;
    do_reset(2);
    rdq_vld     = 1'b0;
    intq_vld    = 1'b0;
    ncu_sii_gnt = 1'b1;
    step();
    ncu_sii_gnt = 1'b0;
    n_checks++;
    if ({gnt_unexp, sii_ncu_req, sii_ncu_data} !== {1'b1, 33'd0})
      $display("FAIL unexp_pulse: got unexp=%b req=%b data=%h want 1/0/0", gnt_unexp, sii_ncu_req, sii_ncu_data);
    else n_pass++;
    step();
    n_checks++;
    if (gnt_unexp !== 1'b0) $display("FAIL unexp_clear: got %b want 0", gnt_unexp);
    else n_pass++;
    par_inj = 1'b1;
    p       = {rand_pkt() >> 32, 32'h0000_0001};
    rdq_pkt = p;
    rdq_vld = 1'b1;
    wait_req(4, seen);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({sii_ncu_req, sii_ncu_data, sii_ncu_dparity} !== {1'b1, 34'd0})
        $display("FAIL unexp_req_quiet %0d: got req=%b data=%h par=%b want 1/0/00",
                 k, sii_ncu_req, sii_ncu_data, sii_ncu_dparity);
      else n_pass++;
      step();
    end
    grant_capture(0);
    for (int n = 0; n < int'(BEATS); n++) begin
      n_checks++;
      if (cap_data[n] !== exp_beat(p, n) || cap_par[n] !== exp_par(exp_beat(p, n), 1'b1))
        $display("FAIL inj_beat %0d: got %h/%b want %h/%b",
                 n, cap_data[n], cap_par[n], exp_beat(p, n), exp_par(exp_beat(p, n), 1'b1));
      else n_pass++;
    end
    n_checks++;
    if (cap_par[BEATS-1] !== 2'b00) $display("FAIL inj_last_par: got %b want 00", cap_par[BEATS-1]);
    else n_pass++;
    rdq_vld = 1'b0;
    step();
    n_checks++;
    if ({sii_ncu_data, sii_ncu_dparity} !== 34'd0)
      $display("FAIL inj_idle: got data=%h par=%b want 0 with par_inj high", sii_ncu_data, sii_ncu_dparity);
    else n_pass++;
    par_inj = 1'b0;
  endtask

  task automatic test_reset_mid_xfer();
    logic [PKT_W-1:0] p;
    logic [38:0]      obs;
    bit               seen, ack_seen;
    do_reset(2);
    p        = rand_pkt();
    intq_pkt = p;
    intq_vld = 1'b1;
    rdq_vld  = 1'b0;
    wait_req(4, seen);
    step();
    ncu_sii_gnt = 1'b1;
    step();
    ncu_sii_gnt = 1'b0;
    ack_seen = intq_ack;
    step();
    ack_seen |= intq_ack;
    step();
    ack_seen |= intq_ack;
    n_checks++;
    if (sii_ncu_data !== exp_beat(p, 2)) $display("FAIL midrst_beat2: got %h want %h", sii_ncu_data, exp_beat(p, 2));
    else n_pass++;
    rst = 1'b1;
    step();
    ack_seen |= intq_ack;
    obs = {sii_ncu_req, sii_ncu_data, sii_ncu_dparity, rdq_ack, intq_ack, gnt_timeout, gnt_unexp};
    n_checks++;
    if (obs !== 39'd0) $display("FAIL midrst_drop: got %h want 0", obs);
    else n_pass++;
    step();
    ack_seen |= intq_ack;
    rst    = 1'b0;
    exp_rr = 1'b0;
    n_checks++;
    if (ack_seen !== 1'b0) $display("FAIL midrst_no_ack: got %b want 0", ack_seen);
    else n_pass++;
    wait_req(4, seen);
    n_checks++;
    if (seen !== 1'b1) $display("FAIL midrst_rereq: got %b want 1", seen);
    else n_pass++;
    grant_capture(2);
    for (int n = 0; n < int'(BEATS); n++) begin
      n_checks++;
      if (cap_data[n] !== exp_beat(p, n) || cap_ack[n] !== exp_ack(n, 1'b1))
        $display("FAIL midrst_resend beat %0d: got %h/%b want %h/%b",
                 n, cap_data[n], cap_ack[n], exp_beat(p, n), exp_ack(n, 1'b1));
      else n_pass++;
    end
    intq_vld = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [PKT_W-1:0] p;
    bit               w, inj;
    int               sel;
    do_reset(2);
    rdq_vld  = 1'b0;
    intq_vld = 1'b0;
    step();
    for (int it = 0; it < 24; it++) begin
      sel      = int'($urandom_range(1, 3));
      rdq_pkt  = rand_pkt();
      intq_pkt = rand_pkt();
      rdq_vld  = sel[0];
      intq_vld = sel[1];
      w = (sel == 3) ? exp_rr : sel[1];
      p = w ? intq_pkt : rdq_pkt;
      step();
      n_checks++;
      if (sii_ncu_req !== 1'b1) $display("FAIL rnd_req it %0d: got %b want 1", it, sii_ncu_req);
      else n_pass++;
      if ($urandom_range(0, 1) == 1) begin
        rdq_pkt  = rand_pkt();
        intq_pkt = rand_pkt();
      end
      if ($urandom_range(0, 1) == 1) begin
        rdq_vld  = 1'b0;
        intq_vld = 1'b0;
      end
      inj     = 1'($urandom_range(0, 1));
      par_inj = inj;
      grant_capture(int'($urandom_range(0, 3)));
      for (int n = 0; n < int'(BEATS); n++) begin
        n_checks++;
        if (cap_data[n] !== exp_beat(p, n) || cap_par[n] !== exp_par(exp_beat(p, n), inj) ||
            cap_ack[n] !== exp_ack(n, w) || cap_req[n] !== 1'b0)
          $display("FAIL rnd_beat it %0d beat %0d: got d=%h p=%b a=%b r=%b want d=%h p=%b a=%b r=0",
                   it, n, cap_data[n], cap_par[n], cap_ack[n], cap_req[n],
                   exp_beat(p, n), exp_par(exp_beat(p, n), inj), exp_ack(n, w));
        else n_pass++;
      end
      exp_rr   = ~w;
      par_inj  = 1'b0;
      rdq_vld  = 1'b0;
      intq_vld = 1'b0;
      step();
      n_checks++;
      if ({sii_ncu_req, sii_ncu_data, sii_ncu_dparity} !== 35'd0)
        $display("FAIL rnd_idle it %0d: got req=%b data=%h par=%b want 0",
                 it, sii_ncu_req, sii_ncu_data, sii_ncu_dparity);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_timeout();
    test_unexp_parity();
    test_reset_mid_xfer();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
